// File: rtl/sipo_always.sv
// sipo_always
//   Free-running reader for a daisy chain of SN74HC165 parallel-load shift
//   registers used as digital input expanders. Every frame pulses SH/LD,
//   clocks WIDTH bits out of the chain on sclk, and publishes the captured
//   word on data with a one-cycle valid strobe.
//
// Ports
//   clk    in   system clock
//   sclr   in   synchronous active-high reset
//   ld_n   out  SH/LD to every 74HC165 (0 = parallel load)
//   sclk   out  shift clock to every 74HC165
//   sdi    in   QH of the last device in the chain (asynchronous)
//   data   out  last accepted frame, first bit shifted out in data[WIDTH-1]
//   valid  out  one-cycle pulse at every frame end
//
// Parameters
//   WIDTH    bits in the chain (8 per device)
//   CLK_DIV  clk cycles per sclk half-period and per load pulse (>= 3)
//
// Build option
//   SIPO_ALWAYS_FILTER_EN : data only updates when two consecutive raw frames
//                           agree (debounce). Undefined: every frame updates.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD     | ld_n low, sclk low for CLK_DIV cycles; chain captures pins
// SHIFT_LO | sclk low for CLK_DIV cycles; sdi sampled on the last cycle
// SHIFT_HI | sclk high for CLK_DIV cycles; rising edge advances the chain
// DONE     | one cycle; publish the frame and strobe valid

module sipo_always #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 10
) (
  input  logic             clk,
  input  logic             sclr,
  output logic             ld_n,
  output logic             sclk,
  input  logic             sdi,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bit;
  logic [1:0]      r_sync;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic            r_ld_n;
  logic            r_sclk;
  logic            r_valid;
`ifdef SIPO_ALWAYS_FILTER_EN
  logic [WIDTH-1:0] r_prev;
`endif

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [BW-1:0]   w_bit_nxt;
  logic            w_sample;
  logic            w_last;
  logic            w_sdi_s;

  assign w_last  = (r_cnt == CNT_LAST);
  assign w_sdi_s = r_sync[1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_last) begin
          w_state_nxt = SHIFT_LO;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      SHIFT_LO: begin
        if (w_last) begin
          w_sample    = 1'b1;
          w_state_nxt = SHIFT_HI;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT_HI: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SHIFT_LO;
            w_bit_nxt   = r_bit + BW'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Pin outputs are registered copies of the current state so the board
  // lines never glitch; data/valid share the same one-cycle offset, which
  // keeps the frame at CLK_DIV*(2*WIDTH+1)+1 cycles measured at the pins.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_sync  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ld_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_valid <= 1'b0;
`ifdef SIPO_ALWAYS_FILTER_EN
      r_prev  <= '0;
`endif
    end else begin
      r_sync  <= {r_sync[0], sdi};
      r_ld_n  <= (r_state != LOAD);
      r_sclk  <= (r_state == SHIFT_HI);
      r_valid <= (r_state == DONE);
      if (w_sample) begin
        r_shift <= {r_shift[WIDTH-2:0], w_sdi_s};
      end
      if (r_state == DONE) begin
`ifdef SIPO_ALWAYS_FILTER_EN
        // Accept only a frame that repeats the previous raw frame.
        if (r_shift == r_prev) begin
          r_data <= r_shift;
        end
        r_prev <= r_shift;
`else
        r_data <= r_shift;
`endif
      end
    end
  end

  assign ld_n  = r_ld_n;
  assign sclk  = r_sclk;
  assign data  = r_data;
  assign valid = r_valid;

endmodule

// File: tb/tb_sipo_always.sv
module tb_sipo_always;

  localparam int WIDTH   = 16;
  localparam int CLK_DIV = 10;
  localparam int FRAME   = CLK_DIV * (2 * WIDTH + 1) + 1;

  logic             clk  = 1'b0;
  logic             sclr = 1'b1;
  logic             ld_n;
  logic             sclk;
  logic             sdi  = 1'b0;
  logic [WIDTH-1:0] data;
  logic             valid;

  logic [WIDTH-1:0] pins  = '0;
  logic [WIDTH-1:0] chain = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sipo_always #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .sclr  (sclr),
    .ld_n  (ld_n),
    .sclk  (sclk),
    .sdi   (sdi),
    .data  (data),
    .valid (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame timing is pure arithmetic on the cycle count since
  // reset release; the expected word is whatever the pins held during the
  // load window of that frame, optionally passed through the two-frame filter.
  logic             rst_q = 1'b1;
  int               cyc = 0;
  int               p = 0;
  int               rises = 0, lows = 0, overlaps = 0;
  logic             prev_sclk = 1'b0;
  logic [WIDTH-1:0] m_raw = '0, m_prev = '0, m_data = '0, last_data = '0;
  logic [WIDTH-1:0] got_data = '0;
  int               valid_cnt = 0;

  always @(posedge clk) rst_q <= sclr;

  always @(negedge clk) begin
    if (rst_q) begin
      cyc = 0; rises = 0; lows = 0; overlaps = 0;
      m_raw = '0; m_prev = '0; m_data = '0;
    end else begin
      cyc++;
      p = (cyc - 1) % FRAME;
      if (!ld_n) lows++;
      if (sclk && !prev_sclk) rises++;
      if (!ld_n && sclk) overlaps++;
      if (p == 5) m_raw = pins;
      if (valid || p == FRAME - 1)
        check("valid_pos", {31'b0, valid}, {31'b0, (p == FRAME - 1)});
      if (p == FRAME - 1) begin
`ifdef SIPO_ALWAYS_FILTER_EN
        if (m_raw == m_prev) m_data = m_raw;
`else
        m_data = m_raw;
`endif
        m_prev = m_raw;
        check("frame_data", 32'(data), 32'(m_data));
        check("sclk_rises", rises, WIDTH);
        check("ld_low_cycles", lows, CLK_DIV);
        check("ld_sclk_overlap", overlaps, 0);
        rises = 0; lows = 0; overlaps = 0;
        got_data = data;
        valid_cnt++;
      end
      if (data !== last_data && !valid)
        check("data_stable", 32'(data), 32'(last_data));
    end
    last_data = data;
    // Behavioural 74HC165 chain: transparent parallel load while SH/LD low,
    // shift toward QH on each rising sclk, serial input of first device tied 0.
    if (ld_n === 1'b0) chain = pins;
    else if (sclk === 1'b1 && !prev_sclk) chain = {chain[WIDTH-2:0], 1'b0};
    sdi = chain[WIDTH-1];
    prev_sclk = (sclk === 1'b1);
  end

  task automatic wait_p(input int target);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (((cyc - 1) % FRAME) != target && n < 2 * FRAME);
    if (n >= 2 * FRAME) check("wait_p_timeout", n, 0);
  endtask

  task automatic wait_valid(output logic [WIDTH-1:0] d);
    int start = valid_cnt;
    int n = 0;
    while (valid_cnt == start && n < 2 * FRAME) begin
      @(posedge clk); #1; n++;
    end
    if (valid_cnt == start) check("valid_timeout", 0, 1);
    d = got_data;
  endtask

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] w;

  initial begin
    // Reset hold
    pins = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold", {13'b0, ld_n, sclk, valid, data}, {13'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    end
    @(posedge clk); #1 sclr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ld_n_first", {31'b0, ld_n}, 32'd0);

    // Static inputs
    wait_valid(d);
`ifdef SIPO_ALWAYS_FILTER_EN
    check("static_first", 32'(d), 32'h0000);
`else
    check("static_first", 32'(d), 32'h1234);
`endif
    wait_valid(d);
    check("static_second", 32'(d), 32'h1234);

    // Input change during shift
    wait_p(150);
    pins = 16'h5678;
    wait_valid(d);
    check("change_frame_n", 32'(d), 32'h1234);
    wait_valid(d);
`ifdef SIPO_ALWAYS_FILTER_EN
    check("change_frame_n1", 32'(d), 32'h1234);
`else
    check("change_frame_n1", 32'(d), 32'h5678);
`endif
    wait_valid(d);
    check("change_frame_n2", 32'(d), 32'h5678);

    // Reset mid-shift
    wait_p(200);
    sclr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 sclr = 1'b0;
    @(negedge clk);
    check("midreset_out", {14'b0, ld_n, sclk, data}, {14'b0, 1'b1, 1'b0, 16'h0000});
    wait_valid(d);
`ifdef SIPO_ALWAYS_FILTER_EN
    check("midreset_frame", 32'(d), 32'h0000);
    wait_valid(d);
`endif
    check("midreset_frame2", 32'(d), 32'h5678);

    // One-load glitch
    wait_p(200);
    pins = 16'h0000;
    wait_valid(d);
    wait_valid(d);
    check("glitch_base", 32'(d), 32'h0000);
    wait_p(200);
    pins = 16'hFFFF;
    wait_valid(d);
    wait_p(200);
    pins = 16'h0000;
    wait_valid(d);
`ifdef SIPO_ALWAYS_FILTER_EN
    check("glitch_frame", 32'(d), 32'h0000);
`else
    check("glitch_frame", 32'(d), 32'hFFFF);
`endif
    wait_valid(d);
    check("glitch_after", 32'(d), 32'h0000);

    // Walking one
    for (int i = 0; i < WIDTH; i++) begin
      w = '0;
      w[i] = 1'b1;
      wait_p(200);
      pins = w;
      wait_valid(d);
      wait_valid(d);
      wait_valid(d);
      check($sformatf("walk_%0d", i), 32'(d), 32'(w));
    end

    // Random inputs, changed at random points of the shift phase
    for (int i = 0; i < 20; i++) begin
      wait_p($urandom_range(300, 50));
      pins = WIDTH'($urandom);
      wait_valid(d);
    end
    wait_valid(d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
